lreport_tx: RTL

- Generates the beacon report message sent from the local LCM toward the controller. It is the transmit-side counterpart of the beacon update receive path.
- Periodically, or on request, it snapshots local configuration and status and serialises it as an 8-word, 134-bit packet into the ESW output mux.
- Payload layout mirrors the update message fields, so the controller can diff the report against the update it sent.

---
 rtl/lreport_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lreport_tx.sv
// rtl/lreport_tx.sv - Beacon report packet generator toward the controller
// Snapshots local config/status on a trigger and emits an 8-word, 134-bit report packet.
module lreport_tx #(
    parameter logic [7:0]  LMID            = 8'd12,
    parameter logic [31:0] REPORT_PERIOD   = 32'd125000,
    parameter logic [15:0] ETH_TYPE        = 16'h1662,
    parameter logic [3:0]  MSG_TYPE_REPORT = 4'he
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_report_en,
    input  logic         in_report_req,
    input  logic         in_beacon_update_master,
    input  logic [47:0]  in_local_mac_id,
    input  logic [47:0]  in_ctrl_mac_id,
    input  logic [31:0]  in_time_slot_period,
    input  logic         in_direction,
    input  logic [15:0]  in_token_bucket_para,
    input  logic [15:0]  in_token_bucket_depth,
    input  logic [47:0]  in_direct_mac_addr,
    input  logic [31:0]  in_rx_pkt_cnt,
    input  logic [31:0]  in_tx_pkt_cnt,
    input  logic [31:0]  in_drop_pkt_cnt,
    input  logic         in_lr_alf,
    output logic [133:0] out_lr_data,
    output logic         out_lr_data_wr,
    output logic         out_lr_data_valid,
    output logic         out_lr_data_valid_wr,
    output logic [15:0]  out_report_seq
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q;
    logic [2:0]     word_q;
    logic [31:0]    period_q, period_d;
    logic           pending_q, pending_d;
    logic           upd_q, upd_init_q;
    logic [15:0]    seq_q;
    logic [47:0]    ctrl_mac_q, local_mac_q, direct_mac_q;
    logic [31:0]    tsp_q, rx_q, tx_q, drop_q;
    logic           dir_q;
    logic [15:0]    tb_para_q, tb_depth_q;
    logic [133:0]   data_q, word_d;
    logic           data_wr_q, valid_q, valid_wr_q;
    logic [15:0]    report_seq_q;
    logic           period_hit, upd_edge, trigger, start;

    // A start is held off for one cycle after a tail word so packets never abut.
    always_comb begin
        period_hit = (REPORT_PERIOD != 32'd0) && in_report_en && (period_q == REPORT_PERIOD - 32'd1);
        upd_edge   = upd_init_q && (in_beacon_update_master != upd_q);
        trigger    = in_report_en && (period_hit || in_report_req || upd_edge);
        start      = (state_q == IDLE) && pending_q && in_report_en && !in_lr_alf && !data_wr_q;

        period_d = period_q;
        if ((REPORT_PERIOD != 32'd0) && in_report_en) begin
            period_d = period_hit ? 32'd0 : period_q + 32'd1;
        end

        pending_d = pending_q;
        if (start || ((state_q == IDLE) && !in_report_en)) begin
            pending_d = 1'b0;
        end else if (trigger) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        word_d = {2'b11, 132'd0};
        case (word_q)
            3'd0: word_d = {2'b01, 4'd0, 1'b1, 7'd0, LMID, 112'd0};
            3'd2: word_d = {2'b11, 4'd0, ctrl_mac_q, local_mac_q, ETH_TYPE, 4'd0, MSG_TYPE_REPORT, seq_q[7:0]};
            3'd3: word_d = {2'b11, 4'd0, seq_q, 112'd0};
            3'd4: word_d = {2'b11, 4'd0, direct_mac_q, dir_q, 15'd0, tb_depth_q, tb_para_q, tsp_q};
            3'd5: word_d = {2'b11, 4'd0, rx_q, tx_q, drop_q, 32'd0};
            3'd7: word_d = {2'b10, 132'd0};
            default: word_d = {2'b11, 132'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_q       <= 3'd0;
            period_q     <= 32'd0;
            pending_q    <= 1'b0;
            upd_q        <= 1'b0;
            upd_init_q   <= 1'b0;
            seq_q        <= 16'd0;
            ctrl_mac_q   <= 48'd0;
            local_mac_q  <= 48'd0;
            direct_mac_q <= 48'd0;
            tsp_q        <= 32'd0;
            rx_q         <= 32'd0;
            tx_q         <= 32'd0;
            drop_q       <= 32'd0;
            dir_q        <= 1'b0;
            tb_para_q    <= 16'd0;
            tb_depth_q   <= 16'd0;
            data_q       <= 134'd0;
            data_wr_q    <= 1'b0;
            valid_q      <= 1'b0;
            valid_wr_q   <= 1'b0;
            report_seq_q <= 16'd0;
        end else begin
            period_q   <= period_d;
            pending_q  <= pending_d;
            upd_q      <= in_beacon_update_master;
            upd_init_q <= 1'b1;
            valid_q    <= 1'b0;
            valid_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= SEND;
                        word_q       <= 3'd1;
                        data_q       <= word_d;
                        data_wr_q    <= 1'b1;
                        ctrl_mac_q   <= in_ctrl_mac_id;
                        local_mac_q  <= in_local_mac_id;
                        direct_mac_q <= in_direct_mac_addr;
                        tsp_q        <= in_time_slot_period;
                        rx_q         <= in_rx_pkt_cnt;
                        tx_q         <= in_tx_pkt_cnt;
                        drop_q       <= in_drop_pkt_cnt;
                        dir_q        <= in_direction;
                        tb_para_q    <= in_token_bucket_para;
                        tb_depth_q   <= in_token_bucket_depth;
                    end else begin
                        word_q    <= 3'd0;
                        data_q    <= 134'd0;
                        data_wr_q <= 1'b0;
                    end
                end
                SEND: begin
                    data_q    <= word_d;
                    data_wr_q <= 1'b1;
                    word_q    <= word_q + 3'd1;
                    if (word_q == 3'd7) begin
                        valid_q      <= 1'b1;
                        valid_wr_q   <= 1'b1;
                        seq_q        <= seq_q + 16'd1;
                        report_seq_q <= seq_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_lr_data          = data_q;
    assign out_lr_data_wr       = data_wr_q;
    assign out_lr_data_valid    = valid_q;
    assign out_lr_data_valid_wr = valid_wr_q;
    assign out_report_seq       = report_seq_q;
endmodule
